// File: rtl/register_file_param.sv
// Parameterised register file: two registered read ports with write-first
// bypass, one byte-masked write port, optional hardwired-zero entry 0, and a
// post-reset sweep that zeroes every entry before writes are accepted.

// One byte lane of the write merge: take the new byte when enabled.
module register_file_param_lane (
  input  logic       en,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module register_file_param #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NBYTES   = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [NBYTES-1:0] writeMask,
  input  logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2,
  output logic              ready
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  old_word, merged;
  logic [WIDTH-1:0]  rd1_nxt, rd2_nxt;
  logic              wr_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Sweep ends on the edge that clears the last entry.
  always_comb begin
    state_nxt = state;
    if (state == INIT && {1'b0, cnt} == LAST_W) state_nxt = RUN;
  end

  // Write acceptance and byte-lane merge against the currently stored word.
  always_comb begin
    wr_ok    = (state == RUN) && regWrite && in_range(writeReg) && !is_zero_reg(writeReg);
    old_word = mem[writeReg];
  end

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    register_file_param_lane u_lane (
      .en       (writeMask[b]),
      .old_byte (old_word[8*b +: 8]),
      .new_byte (writeData[8*b +: 8]),
      .merged   (merged[8*b +: 8])
    );
  end

  // Next read values: zero when sweeping/out of range/zero reg, else write-first.
  always_comb begin
    rd1_nxt = '0;
    rd2_nxt = '0;
    if (state == RUN && in_range(readReg1) && !is_zero_reg(readReg1))
      rd1_nxt = (wr_ok && readReg1 == writeReg) ? merged : mem[readReg1];
    if (state == RUN && in_range(readReg2) && !is_zero_reg(readReg2))
      rd2_nxt = (wr_ok && readReg2 == writeReg) ? merged : mem[readReg2];
  end

  // Control state, sweep counter, ready flag and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      ready     <= 1'b0;
      readData1 <= '0;
      readData2 <= '0;
    end else begin
      state     <= state_nxt;
      ready     <= (state_nxt == RUN);
      if (state == INIT) cnt <= cnt + ADDR_W'(1);
      readData1 <= rd1_nxt;
      readData2 <= rd2_nxt;
    end
  end

  // Storage: sweep zeroes one entry per cycle; afterwards accepted writes land.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)  mem[cnt]      <= '0;
      else if (wr_ok)     mem[writeReg] <= merged;
    end
  end

endmodule
